// File: rtl/ecap5_dproc_pkg.sv
// rtl/ecap5_dproc_pkg.sv - shared op codes and state type for the multiply/divide unit
package ecap5_dproc_pkg;

  localparam logic [2:0] MULDIV_MUL    = 3'b000;
  localparam logic [2:0] MULDIV_MULH   = 3'b001;
  localparam logic [2:0] MULDIV_MULHSU = 3'b010;
  localparam logic [2:0] MULDIV_MULHU  = 3'b011;
  localparam logic [2:0] MULDIV_DIV    = 3'b100;
  localparam logic [2:0] MULDIV_DIVU   = 3'b101;
  localparam logic [2:0] MULDIV_REM    = 3'b110;
  localparam logic [2:0] MULDIV_REMU   = 3'b111;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_PREP,
    MD_ITER,
    MD_FIX,
    MD_DONE
  } muldiv_state_t;

endpackage

// File: rtl/exm_muldiv_if.sv
// rtl/exm_muldiv_if.sv - request/result handshake bundle of the multiply/divide unit
interface exm_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             flush_i;
  logic             input_valid_i;
  logic             input_ready_o;
  logic [WIDTH-1:0] operand1_i;
  logic [WIDTH-1:0] operand2_i;
  logic [2:0]       op_i;
  logic             result_write_i;
  logic [4:0]       result_addr_i;
  logic             output_ready_i;
  logic             output_valid_o;
  logic [WIDTH-1:0] result_o;
  logic             result_write_o;
  logic [4:0]       result_addr_o;

  modport master (
    output flush_i, input_valid_i, operand1_i, operand2_i, op_i,
           result_write_i, result_addr_i, output_ready_i,
    input  input_ready_o, output_valid_o, result_o, result_write_o, result_addr_o
  );

  modport slave (
    input  flush_i, input_valid_i, operand1_i, operand2_i, op_i,
           result_write_i, result_addr_i, output_ready_i,
    output input_ready_o, output_valid_o, result_o, result_write_o, result_addr_o
  );
endinterface

// File: rtl/exm_muldiv_step.sv
// rtl/exm_muldiv_step.sv - one iteration of shift-add multiply or restoring divide
module muldiv_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] diff;
  logic [WIDTH:0] sum;

  // Multiply shifts right with the carry; divide shifts left and retires a quotient bit at the bottom.
  always_comb begin
    acc_next = acc;
    diff     = '0;
    sum      = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        diff = acc_next[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (!diff[WIDTH]) begin
          acc_next = {diff[WIDTH-1:0], acc_next[WIDTH-2:0], 1'b1};
        end else begin
          acc_next = {acc_next[2*WIDTH-2:0], 1'b0};
        end
      end else begin
        sum      = {1'b0, acc_next[2*WIDTH-1:WIDTH]} + {1'b0, (acc_next[0] ? operand : {WIDTH{1'b0}})};
        acc_next = {sum, acc_next[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/exm_muldiv.sv
// rtl/exm_muldiv.sv - iterative RV32M multiply/divide unit with flush and result hold
module exm_muldiv
  import ecap5_dproc_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic         clk_i,
  input logic         rst_i,
  exm_muldiv_if.slave bus
);

  localparam int K  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(K) + 1;

  muldiv_state_t      state, next_state;
  logic [WIDTH-1:0]   a_q, b_q, opnd, res_q;
  logic [2:0]         op_q;
  logic               wr_q, valid_q, sign1, sign2;
  logic [4:0]         addr_q;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [CW-1:0]      cnt;
  logic               is_div, a_signed, b_signed, neg, div0;
  logic [WIDTH-1:0]   a_mag, b_mag, q, r, fix_result;

  assign is_div   = op_q[2];
  assign a_signed = (op_q == MULDIV_MUL) || (op_q == MULDIV_MULH) || (op_q == MULDIV_MULHSU)
                 || (op_q == MULDIV_DIV) || (op_q == MULDIV_REM);
  assign b_signed = (op_q == MULDIV_MUL) || (op_q == MULDIV_MULH)
                 || (op_q == MULDIV_DIV) || (op_q == MULDIV_REM);
  assign a_mag    = (a_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag    = (b_signed && b_q[WIDTH-1]) ? -b_q : b_q;

  muldiv_step #(.WIDTH(WIDTH), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .is_div   (is_div),
    .acc_next (acc_step)
  );

  // Signed overflow needs no special case: the magnitude path already yields MIN and 0.
  always_comb begin
    neg  = sign1 ^ sign2;
    prod = neg ? -acc : acc;
    q    = acc[WIDTH-1:0];
    r    = acc[2*WIDTH-1:WIDTH];
    div0 = (opnd == '0);
    case (op_q)
      MULDIV_MUL:                 fix_result = prod[WIDTH-1:0];
      MULDIV_MULH, MULDIV_MULHSU,
      MULDIV_MULHU:               fix_result = prod[2*WIDTH-1:WIDTH];
      MULDIV_DIV, MULDIV_DIVU:    fix_result = div0 ? '1 : (neg ? -q : q);
      default:                    fix_result = div0 ? a_q : (sign1 ? -r : r);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= MD_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      MD_IDLE: if (bus.input_valid_i) next_state = MD_PREP;
      MD_PREP: next_state = MD_ITER;
      MD_ITER: if (cnt == CW'(K - 1)) next_state = MD_FIX;
      MD_FIX:  next_state = MD_DONE;
      MD_DONE: if (bus.output_ready_i) next_state = MD_IDLE;
      default: next_state = MD_IDLE;
    endcase
    if (bus.flush_i) next_state = MD_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q <= '0; b_q <= '0; opnd <= '0; res_q <= '0; op_q <= '0;
      wr_q <= 1'b0; addr_q <= '0; valid_q <= 1'b0;
      sign1 <= 1'b0; sign2 <= 1'b0; acc <= '0; cnt <= '0;
    end else begin
      case (state)
        MD_IDLE: if (bus.input_valid_i && !bus.flush_i) begin
          a_q    <= bus.operand1_i;
          b_q    <= bus.operand2_i;
          op_q   <= bus.op_i;
          wr_q   <= bus.result_write_i;
          addr_q <= bus.result_addr_i;
        end
        MD_PREP: begin
          sign1 <= a_signed && a_q[WIDTH-1];
          sign2 <= b_signed && b_q[WIDTH-1];
          acc   <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          opnd  <= is_div ? b_mag : a_mag;
          cnt   <= '0;
        end
        MD_ITER: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        MD_FIX: begin
          res_q   <= fix_result;
          valid_q <= 1'b1;
        end
        MD_DONE: if (bus.output_ready_i) valid_q <= 1'b0;
        default: ;
      endcase
      if (bus.flush_i) valid_q <= 1'b0;
    end
  end

  assign bus.input_ready_o  = (state == MD_IDLE);
  assign bus.output_valid_o = valid_q;
  assign bus.result_o       = res_q;
  assign bus.result_write_o = wr_q;
  assign bus.result_addr_o  = addr_q;

endmodule
